// File: rtl/goofy_alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the flag set.
// Optional multiplier is enabled by defining GOOFY_ALU_MUL_EN.
package goofy_alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_SBB = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_NOT = 4'd6,
    OP_CMP = 4'd7,
    OP_HLT = 4'd8,
    OP_SHL = 4'd9,
    OP_SHR = 4'd10,
    OP_MUL = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_e;

  typedef struct packed {
    logic ov;
    logic eq;
    logic zero;
    logic hlt;
    logic ill;
  } flags_t;

endpackage

// File: rtl/goofy_alu_if.sv
// Operand write bus, opcode handshake, result and flag bundle of goofy_alu_seq.
interface goofy_alu_if
  import goofy_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic             a_we;
  logic [WIDTH-1:0] a_d;
  logic             b_we;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] a_o;
  logic [WIDTH-1:0] b_o;
  logic [OP_W-1:0]  op;
  logic             op_valid;
  logic             op_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] out_hi;
  logic             flag_clr;
  logic             flag_ov;
  logic             flag_eq;
  logic             flag_zero;
  logic             flag_hlt;
  logic             flag_ill;

  modport master (
    output a_we, a_d, b_we, b_d, op, op_valid, flag_clr,
    input  a_o, b_o, op_ready, out_valid, out_data, out_hi,
           flag_ov, flag_eq, flag_zero, flag_hlt, flag_ill
  );

  modport slave (
    input  a_we, a_d, b_we, b_d, op, op_valid, flag_clr,
    output a_o, b_o, op_ready, out_valid, out_data, out_hi,
           flag_ov, flag_eq, flag_zero, flag_hlt, flag_ill
  );

endinterface

// File: rtl/goofy_alu_mul_iter.sv
// Shift-add unsigned multiplier: one partial product per clock, WIDTH steps.
// The first step is folded into the start cycle so the product is ready WIDTH-1 edges later.
module goofy_alu_mul_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_c,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  // One step: conditionally add multiplicand to the high half, then shift {carry,hi,lo} right.
  function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] m,
                                              input logic [WIDTH-1:0] h,
                                              input logic [WIDTH-1:0] l);
    logic [WIDTH:0] s;
    s = {1'b0, h} + (l[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {s, l[WIDTH-1:1]};
  endfunction

  assign done_c = busy_q && (cnt_q == CW'(WIDTH));
  assign hi     = hi_q;
  assign lo     = lo_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start) begin
      mcand_q      <= a;
      {hi_q, lo_q} <= step(a, {WIDTH{1'b0}}, b);
      cnt_q        <= CW'(1);
      busy_q       <= 1'b1;
    end else if (done_c) begin
      busy_q <= 1'b0;
    end else if (busy_q) begin
      {hi_q, lo_q} <= step(mcand_q, hi_q, lo_q);
      cnt_q        <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/goofy_alu_seq.sv
// Multi-cycle ALU with operand registers, flag set and valid/ready opcode handshake.
// Define GOOFY_ALU_MUL_EN to build the iterative multiplier for opcode 11.
module goofy_alu_seq
  import goofy_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic        clk,
  input logic        res,
  goofy_alu_if.slave bus
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [OP_W-1:0]  op_q;
  logic             cin_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  flags_t           flag_q;
  flags_t           flag_d;
  flags_t           flag_wr_c;
  flags_t           flag_val_c;
  logic [WIDTH-1:0] result_c;
  logic             cout_c;
  logic             upd_c;
  logic             accept_c;
  logic             op_ready_c;

`ifdef GOOFY_ALU_MUL_EN
  logic             mul_start_c;
  logic             mul_done_c;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH-1:0] hi_c;
  logic [WIDTH-1:0] out_hi_q;

  goofy_alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .res    (res),
    .start  (mul_start_c),
    .a      (a_q),
    .b      (b_q),
    .done_c (mul_done_c),
    .hi     (mul_hi),
    .lo     (mul_lo)
  );

  assign bus.out_hi = out_hi_q;
`else
  assign bus.out_hi = '0;
`endif

  assign op_ready_c    = (state_q == ST_IDLE) && !flag_q.hlt;
  assign accept_c      = bus.op_valid && op_ready_c;
  assign bus.op_ready  = op_ready_c;
  assign bus.a_o       = a_q;
  assign bus.b_o       = b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.flag_ov   = flag_q.ov;
  assign bus.flag_eq   = flag_q.eq;
  assign bus.flag_zero = flag_q.zero;
  assign bus.flag_hlt  = flag_q.hlt;
  assign bus.flag_ill  = flag_q.ill;

  always_ff @(posedge clk or posedge res) begin
    if (res) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, result and per-flag write enables/values for the completing op.
  always_comb begin
    state_d    = state_q;
    upd_c      = 1'b0;
    result_c   = out_data_q;
    cout_c     = 1'b0;
    flag_wr_c  = '0;
    flag_val_c = '0;
`ifdef GOOFY_ALU_MUL_EN
    mul_start_c = 1'b0;
    hi_c        = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
`ifdef GOOFY_ALU_MUL_EN
          if (bus.op == OP_MUL) begin
            state_d     = ST_MUL;
            mul_start_c = 1'b1;
          end else begin
            state_d = ST_EXEC;
          end
`else
          state_d = ST_EXEC;
`endif
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        upd_c   = 1'b1;
        case (op_q)
          OP_ADD: begin
            {cout_c, result_c} = {1'b0, opa_q} + {1'b0, opb_q};
            flag_wr_c.ov   = 1'b1;
            flag_wr_c.zero = 1'b1;
          end
          OP_ADC: begin
            {cout_c, result_c} = {1'b0, opa_q} + {1'b0, opb_q} + (WIDTH+1)'(cin_q);
            flag_wr_c.ov   = 1'b1;
            flag_wr_c.zero = 1'b1;
          end
          OP_SUB: begin
            {cout_c, result_c} = {1'b0, opa_q} - {1'b0, opb_q};
            flag_wr_c.ov   = 1'b1;
            flag_wr_c.zero = 1'b1;
          end
          OP_SBB: begin
            {cout_c, result_c} = {1'b0, opa_q} - {1'b0, opb_q} - (WIDTH+1)'(cin_q);
            flag_wr_c.ov   = 1'b1;
            flag_wr_c.zero = 1'b1;
          end
          OP_AND: begin
            result_c       = opa_q & opb_q;
            flag_wr_c.zero = 1'b1;
          end
          OP_OR: begin
            result_c       = opa_q | opb_q;
            flag_wr_c.zero = 1'b1;
          end
          OP_NOT: begin
            result_c       = ~opa_q;
            flag_wr_c.zero = 1'b1;
          end
          OP_CMP: begin
            {cout_c, result_c} = {1'b0, opa_q} - {1'b0, opb_q};
            flag_val_c.eq  = (opa_q == opb_q);
            flag_wr_c.ov   = 1'b1;
            flag_wr_c.eq   = 1'b1;
            flag_wr_c.zero = 1'b1;
          end
          OP_HLT: begin
            flag_wr_c.hlt  = 1'b1;
            flag_val_c.hlt = 1'b1;
          end
          OP_SHL: begin
            result_c       = opa_q << opb_q[SHW-1:0];
            flag_wr_c.zero = 1'b1;
          end
          OP_SHR: begin
            result_c       = opa_q >> opb_q[SHW-1:0];
            flag_wr_c.zero = 1'b1;
          end
          default: begin
            result_c       = '0;
            flag_wr_c.ill  = 1'b1;
            flag_val_c.ill = 1'b1;
          end
        endcase
        flag_val_c.ov   = cout_c;
        flag_val_c.zero = (result_c == '0);
      end
`ifdef GOOFY_ALU_MUL_EN
      ST_MUL: begin
        if (mul_done_c) begin
          state_d         = ST_IDLE;
          upd_c           = 1'b1;
          result_c        = mul_lo;
          hi_c            = mul_hi;
          flag_wr_c.ov    = 1'b1;
          flag_wr_c.zero  = 1'b1;
          flag_val_c.ov   = (mul_hi != '0);
          flag_val_c.zero = (mul_lo == '0);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Flags written by a completing op win over flag_clr; everything else clears.
  always_comb begin
    flag_d = bus.flag_clr ? flags_t'(5'b0) : flag_q;
    if (upd_c) flag_d = flags_t'((flag_wr_c & flag_val_c) | (~flag_wr_c & flag_d));
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      a_q         <= '0;
      b_q         <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      op_q        <= '0;
      cin_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      flag_q      <= '0;
`ifdef GOOFY_ALU_MUL_EN
      out_hi_q    <= '0;
`endif
    end else begin
      if (bus.a_we) a_q <= bus.a_d;
      if (bus.b_we) b_q <= bus.b_d;
      if (accept_c) begin
        op_q  <= bus.op;
        opa_q <= a_q;
        opb_q <= b_q;
        cin_q <= flag_q.ov;
      end
      out_valid_q <= upd_c;
      if (upd_c) begin
        out_data_q <= result_c;
`ifdef GOOFY_ALU_MUL_EN
        out_hi_q   <= hi_c;
`endif
      end
      flag_q <= flag_d;
    end
  end

endmodule
